// File: rtl/ifq_pkg.sv
// ifq_pkg: shared widths, FIFO entry type and request-FSM encoding for the instruction-fetch queue.
// Rev 1.0
`default_nettype none

package ifq_pkg;

  localparam int ADDR_W        = 8;
  localparam int INSTR_W       = 16;
  localparam int DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ifq_fifo.sv
// ifq_fifo: power-of-two circular buffer of {addr, instr} entries with push/pop/flush and occupancy count.
// Rev 1.0
`default_nettype none

module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  entry_t                   wr_data,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t            store [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: head is only consumed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push && !flush) store[wr_ptr] <= wr_data;
  end

  assign head = store[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/ifetch_queue.sv
// ifetch_queue: prefetch FIFO feeding the core's ir, with PC-compare redirect and single-outstanding fetch.
// Rev 1.0 -- define IFQ_BYPASS_EN to forward mem_rdata straight to ir on an empty-queue hit.
`default_nettype none

module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               ir_take,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] fetch_addr_n;
  logic [ADDR_W-1:0] redir_addr;
  logic [ADDR_W-1:0] redir_addr_n;
  logic              drop;
  logic              drop_n;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_n;
  entry_t            head;
  entry_t            wr_entry;
  logic [ADDR_W-1:0] exp_addr;
  logic              fifo_hit;
  logic              bypass_hit;
  logic              redirect;
  logic              accept;
  logic              push;
  logic              pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      fetch_addr <= '0;
      redir_addr <= '0;
    end else begin
      state      <= state_n;
      fetch_addr <= fetch_addr_n;
      redir_addr <= redir_addr_n;
    end
  end

  assign drop     = (state == ST_DROP);
  assign mem_req  = (state != ST_IDLE);
  assign mem_addr = fetch_addr;
  assign accept   = mem_req & mem_ack;

  assign exp_addr = (count != '0) ? head.addr : (drop ? redir_addr : fetch_addr);
  assign redirect = (pc != exp_addr);
  assign fifo_hit = (count != '0) && (pc == head.addr);
  assign pop      = fifo_hit & ir_take;

`ifdef IFQ_BYPASS_EN
  assign bypass_hit = (count == '0) && !drop && accept && (fetch_addr == pc);
`else
  assign bypass_hit = 1'b0;
`endif

  always_comb begin
    ir_valid = fifo_hit;
    ir       = fifo_hit ? head.instr : '0;
`ifdef IFQ_BYPASS_EN
    if (bypass_hit) begin
      ir_valid = 1'b1;
      ir       = mem_rdata;
    end
`endif
  end

  // The in-flight request is never retracted: a redirect without an ack
  // parks the new target in redir_addr until the stale word comes back.
  always_comb begin
    fetch_addr_n = fetch_addr;
    redir_addr_n = redir_addr;
    drop_n       = drop;
    push         = 1'b0;
    if (accept) begin
      drop_n = 1'b0;
      if (redirect) begin
        fetch_addr_n = pc;
      end else if (drop) begin
        fetch_addr_n = redir_addr;
      end else begin
        push         = ~(bypass_hit & ir_take);
        fetch_addr_n = fetch_addr + ADDR_W'(1);
      end
    end else if (redirect) begin
      if (mem_req) begin
        drop_n       = 1'b1;
        redir_addr_n = pc;
      end else begin
        fetch_addr_n = pc;
      end
    end

    count_n = redirect ? '0 : count + CNT_W'(push) - CNT_W'(pop);

    if (drop_n)                           state_n = ST_DROP;
    else if (count_n == CNT_W'(DEPTH))    state_n = ST_IDLE;
    else                                  state_n = ST_REQ;
  end

  assign wr_entry = '{addr: fetch_addr, instr: mem_rdata};

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (redirect),
    .wr_data (wr_entry),
    .head    (head),
    .count   (count)
  );

endmodule

`default_nettype wire

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: scoreboard bench for ifetch_queue with a variable-latency memory responder.
// Rev 1.0
`default_nettype none

module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pc;
  logic        ir_take;
  logic [15:0] ir;
  logic        ir_valid;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  int          lat;
  int          wait_cnt;
  int          tests;
  int          failed;
  logic [15:0] exp_q [$];
  logic [7:0]  ack_log [$];

`ifdef IFQ_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  ifetch_queue dut (
    .clk       (clk),
    .reset     (reset),
    .pc        (pc),
    .ir_take   (ir_take),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memword(input logic [7:0] a);
    return {a ^ 8'h5A, ~a};
  endfunction

  // Memory responder: acks after the request has been held for lat cycles.
  assign mem_ack   = mem_req && (wait_cnt >= lat);
  assign mem_rdata = memword(mem_addr);

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
  end

  always @(negedge clk) begin
    if (mem_req && mem_ack) ack_log.push_back(mem_addr);
  end

  task automatic run_fetch(input logic [7:0] start, input int n, input int budget, output int cycles);
    logic [15:0] e;
    int got;
    pc      = start;
    ir_take = 1'b1;
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(memword(start + 8'(k)));
    got    = 0;
    cycles = 0;
    while (got < n && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (ir_valid) begin
        e = exp_q.pop_front();
        tests++;
        if (ir !== e) begin
          failed++;
          $display("FAIL fetch_ir pc=%h ir=%h expected=%h", pc, ir, e);
        end
        got++;
        @(posedge clk);
        #1;
        pc = pc + 8'd1;
      end
    end
    ir_take = 1'b0;
    if (got < n) begin
      tests++;
      failed++;
      $display("FAIL fetch_timeout start=%h delivered=%0d expected=%0d", start, got, n);
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    tests += 4;
    if (mem_req !== 1'b0)   begin failed++; $display("FAIL reset_mem_req got=%b expected=0", mem_req); end
    if (ir_valid !== 1'b0)  begin failed++; $display("FAIL reset_ir_valid got=%b expected=0", ir_valid); end
    if (mem_addr !== 8'h00) begin failed++; $display("FAIL reset_mem_addr got=%h expected=00", mem_addr); end
    if (ir !== 16'h0000)    begin failed++; $display("FAIL reset_ir got=%h expected=0000", ir); end
  endtask

  task automatic test_fill;
    int  k;
    logic found;
    ack_log.delete();
    reset = 1'b1;
    found = 1'b0;
    k = 0;
    while (!found && k < 10) begin
      @(negedge clk);
      k++;
      if (mem_req && mem_ack) found = 1'b1;
    end
    tests++;
    if (!found) begin
      failed++;
      $display("FAIL first_ack timeout got=none expected=ack within 10 cycles");
    end else begin
      tests += 2;
      if (mem_addr !== 8'h00) begin failed++; $display("FAIL first_addr got=%h expected=00", mem_addr); end
      if (ir_valid !== BYP)   begin failed++; $display("FAIL ack_cycle_valid got=%b expected=%b", ir_valid, BYP); end
      @(negedge clk);
      tests += 2;
      if (ir_valid !== 1'b1)     begin failed++; $display("FAIL miss_latency_valid got=%b expected=1", ir_valid); end
      if (ir !== memword(8'h00)) begin failed++; $display("FAIL miss_latency_ir got=%h expected=%h", ir, memword(8'h00)); end
    end
    repeat (12) @(negedge clk);
    #1;
    tests += 2;
    if (ack_log.size() != 4) begin failed++; $display("FAIL fill_req_count got=%0d expected=4", ack_log.size()); end
    if (mem_req !== 1'b0)    begin failed++; $display("FAIL fill_mem_req got=%b expected=0", mem_req); end
    for (int i = 0; i < 4 && i < ack_log.size(); i++) begin
      tests++;
      if (ack_log[i] !== 8'(i)) begin
        failed++;
        $display("FAIL fill_addr idx=%0d got=%h expected=%h", i, ack_log[i], 8'(i));
      end
    end
  endtask

  task automatic test_drain;
    int cyc;
    run_fetch(8'h00, 10, 80, cyc);
  endtask

  task automatic test_back_to_back;
    int cyc;
    lat = 0;
    run_fetch(pc, 16, 60, cyc);
    tests++;
    if (cyc > 18) begin failed++; $display("FAIL throughput cycles=%0d expected<=18", cyc); end
  endtask

  task automatic test_jump;
    int cyc;
    int k;
    repeat (8) @(negedge clk);
    tests += 2;
    if (ir_valid !== 1'b1)  begin failed++; $display("FAIL prejump_valid got=%b expected=1", ir_valid); end
    if (ir !== memword(pc)) begin failed++; $display("FAIL prejump_ir got=%h expected=%h", ir, memword(pc)); end
    @(posedge clk);
    #1;
    pc = 8'h40;
    ack_log.delete();
    @(negedge clk);
    tests++;
    if (ir_valid !== 1'b0) begin failed++; $display("FAIL jump_cycle_valid got=%b expected=0", ir_valid); end
    k = 0;
    #1;
    while (ack_log.size() == 0 && k < 10) begin
      @(negedge clk);
      #1;
      k++;
    end
    tests++;
    if (ack_log.size() == 0) begin
      failed++;
      $display("FAIL jump_addr timeout got=none expected=40");
    end else if (ack_log[0] !== 8'h40) begin
      failed++;
      $display("FAIL jump_addr got=%h expected=40", ack_log[0]);
    end
    run_fetch(8'h40, 6, 40, cyc);
  endtask

  task automatic test_redirect_inflight;
    int cyc;
    int k;
    logic found;
    logic acked;
    logic [7:0] held;
    lat = 3;
    run_fetch(8'h00, 6, 100, cyc);
    found = 1'b0;
    k = 0;
    while (!found && k < 20) begin
      @(negedge clk);
      k++;
      if (mem_req && !mem_ack && wait_cnt == 0) found = 1'b1;
    end
    tests++;
    if (!found) begin
      failed++;
      $display("FAIL inflight_search timeout got=none expected=new request");
    end else begin
      held = mem_addr;
      @(posedge clk);
      #1;
      pc = 8'h80;
      acked = 1'b0;
      k = 0;
      while (!acked && k < 8) begin
        @(negedge clk);
        k++;
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== held) begin
          failed++;
          $display("FAIL inflight_hold req=%b addr=%h expected req=1 addr=%h", mem_req, mem_addr, held);
        end
        if (mem_req && mem_ack) acked = 1'b1;
      end
      tests++;
      if (!acked) begin
        failed++;
        $display("FAIL inflight_ack timeout got=none expected=ack");
      end
      @(negedge clk);
      tests++;
      if (mem_req !== 1'b1 || mem_addr !== 8'h80) begin
        failed++;
        $display("FAIL redirect_addr req=%b addr=%h expected req=1 addr=80", mem_req, mem_addr);
      end
      run_fetch(8'h80, 5, 80, cyc);
    end
  endtask

  task automatic test_wrap;
    int cyc;
    int idx;
    logic [7:0] want;
    lat = 0;
    ack_log.delete();
    run_fetch(8'hFE, 6, 40, cyc);
    #1;
    idx = -1;
    for (int i = 0; i < ack_log.size(); i++) begin
      if (idx < 0 && ack_log[i] == 8'hFE) idx = i;
    end
    for (int j = 1; j < 4; j++) begin
      want = 8'hFE + 8'(j);
      tests++;
      if (idx < 0 || idx + j >= ack_log.size()) begin
        failed++;
        $display("FAIL wrap_seq step=%0d got=missing expected=%h", j, want);
      end else if (ack_log[idx + j] !== want) begin
        failed++;
        $display("FAIL wrap_seq step=%0d got=%h expected=%h", j, ack_log[idx + j], want);
      end
    end
  endtask

  task automatic test_reset_midflight;
    int cyc;
    int k;
    logic found;
    lat = 5;
    run_fetch(8'h20, 2, 60, cyc);
    found = 1'b0;
    k = 0;
    while (!found && k < 40) begin
      @(negedge clk);
      k++;
      if (mem_req && !mem_ack && ir_valid) found = 1'b1;
    end
    tests++;
    if (!found) begin
      failed++;
      $display("FAIL midflight_search timeout got=none expected=busy state");
    end
    reset = 1'b0;
    #1;
    tests += 3;
    if (mem_req !== 1'b0)   begin failed++; $display("FAIL midreset_mem_req got=%b expected=0", mem_req); end
    if (ir_valid !== 1'b0)  begin failed++; $display("FAIL midreset_ir_valid got=%b expected=0", ir_valid); end
    if (mem_addr !== 8'h00) begin failed++; $display("FAIL midreset_mem_addr got=%h expected=00", mem_addr); end
    @(posedge clk);
    @(negedge clk);
    pc  = 8'h00;
    lat = 1;
    ack_log.delete();
    reset = 1'b1;
    run_fetch(8'h00, 4, 40, cyc);
    #1;
    tests++;
    if (ack_log.size() == 0) begin
      failed++;
      $display("FAIL restart_addr got=none expected=00");
    end else if (ack_log[0] !== 8'h00) begin
      failed++;
      $display("FAIL restart_addr got=%h expected=00", ack_log[0]);
    end
  endtask

  initial begin
    tests   = 0;
    failed  = 0;
    reset   = 1'b0;
    pc      = 8'h00;
    ir_take = 1'b0;
    lat     = 1;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_jump();
    test_redirect_inflight();
    test_wrap();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
